// File: rtl/padding_stream.sv
// Row-streaming image padder.
// Accepts one full row (all channels) per valid/ready transfer and emits
// H+2P rows of width W+2P per channel, with zero or edge-replicate borders.
module padding_stream #(
    parameter int DW  = 8,
    parameter int W   = 416,
    parameter int H   = 416,
    parameter int C   = 3,
    parameter int P   = 1,
    parameter int RCW = 10
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    pad_mode,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [C*W*DW-1:0]       in_row,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [C*(W+2*P)*DW-1:0] out_row,
    output logic [RCW-1:0]          out_row_idx,
    output logic                    busy,
    output logic                    frame_done
);

    localparam int OW  = W + 2 * P;
    localparam int IRW = C * W * DW;
    localparam int ORW = C * OW * DW;
    // Last phase-counter value of the top/bottom pad phases and the body phase
    localparam logic [RCW-1:0] PAD_LAST  = RCW'((P > 0) ? P - 1 : 0);
    localparam logic [RCW-1:0] BODY_LAST = RCW'(H - 1);

    // DRAIN waits for the final output row to be taken before going idle
    typedef enum logic [2:0] {
        S_IDLE,
        S_TOP,
        S_BODY,
        S_BOTTOM,
        S_DRAIN
    } state_t;

    state_t         state_reg, state_next;
    logic           mode_reg, mode_next;
    logic [RCW-1:0] phase_reg, phase_next;
    logic [RCW-1:0] row_idx_reg, row_idx_next;
    logic [IRW-1:0] stored_reg;

    logic           adv;
    logic           produce;
    logic           consume;
    logic           zero_row;
    logic [IRW-1:0] src_row;
    logic [ORW-1:0] padded_row;

    assign adv        = !out_valid || out_ready;
    assign busy       = (state_reg != S_IDLE);
    assign frame_done = (state_reg == S_DRAIN) && out_valid && out_ready;
    // Bottom replicate rows come from the last body row; everything else from the input
    assign src_row    = (state_reg == S_BOTTOM) ? stored_reg : in_row;

    // Horizontal padding: each output pixel selects a fixed source pixel or zero
    genvar gi, gj;
    generate
        for (gi = 0; gi < C; gi++) begin : g_ch
            for (gj = 0; gj < OW; gj++) begin : g_px
                localparam bit EDGE = (gj < P) || (gj >= P + W);
                localparam int SX   = (gj < P) ? 0 : ((gj >= P + W) ? W - 1 : gj - P);
                assign padded_row[(gi*OW+gj)*DW +: DW] =
                    (zero_row || (EDGE && !mode_reg)) ? {DW{1'b0}} : src_row[(gi*W+SX)*DW +: DW];
            end
        end
    endgenerate

    // Next-state, row production and input handshake decisions
    always_comb begin
        state_next   = state_reg;
        mode_next    = mode_reg;
        phase_next   = phase_reg;
        row_idx_next = row_idx_reg;
        produce      = 1'b0;
        consume      = 1'b0;
        zero_row     = 1'b0;
        in_ready     = 1'b0;
        unique case (state_reg)
            S_IDLE: begin
                if (start) begin
                    mode_next    = pad_mode;
                    phase_next   = '0;
                    row_idx_next = '0;
                    state_next   = (P > 0) ? S_TOP : S_BODY;
                end
            end
            S_TOP: begin
                zero_row = !mode_reg;
                // Replicate mode peeks at the first row without consuming it
                produce  = adv && (!mode_reg || in_valid);
                if (produce) begin
                    if (phase_reg == PAD_LAST) begin
                        phase_next = '0;
                        state_next = S_BODY;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            S_BODY: begin
                in_ready = adv;
                consume  = adv && in_valid;
                produce  = consume;
                if (consume) begin
                    if (phase_reg == BODY_LAST) begin
                        phase_next = '0;
                        state_next = (P > 0) ? S_BOTTOM : S_DRAIN;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            S_BOTTOM: begin
                zero_row = !mode_reg;
                produce  = adv;
                if (produce) begin
                    if (phase_reg == PAD_LAST) begin
                        phase_next = '0;
                        state_next = S_DRAIN;
                    end else begin
                        phase_next = phase_reg + 1'b1;
                    end
                end
            end
            S_DRAIN: begin
                if (out_valid && out_ready) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
        if (produce) begin
            row_idx_next = row_idx_reg + 1'b1;
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg   <= S_IDLE;
            mode_reg    <= 1'b0;
            phase_reg   <= '0;
            row_idx_reg <= '0;
        end else begin
            state_reg   <= state_next;
            mode_reg    <= mode_next;
            phase_reg   <= phase_next;
            row_idx_reg <= row_idx_next;
        end
    end

    // Keep a copy of each consumed body row for bottom replication
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stored_reg <= '0;
        end else if (consume) begin
            stored_reg <= in_row;
        end
    end

    // Output register: loads only when a row is produced, holds under back-pressure
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid   <= 1'b0;
            out_row     <= '0;
            out_row_idx <= '0;
        end else if (produce) begin
            out_valid   <= 1'b1;
            out_row     <= padded_row;
            out_row_idx <= row_idx_reg;
        end else if (out_ready) begin
            out_valid   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_padding_stream.sv
// Self-checking bench for padding_stream: three instances (P=1, P=2, P=0)
// share data inputs; only the instance being started runs a frame.
module tb_padding_stream;

    localparam int DW   = 8;
    localparam int W    = 4;
    localparam int H    = 3;
    localparam int C    = 2;
    localparam int RCW  = 4;
    localparam int IRW  = C * W * DW;
    localparam int MAXW = C * (W + 4) * DW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic           start_v [3];
    logic           pad_mode;
    logic           in_valid;
    logic           out_ready;
    logic [IRW-1:0] in_row;

    logic            in_ready_w  [3];
    logic            out_valid_w [3];
    logic            busy_w      [3];
    logic            fd_w        [3];
    logic [RCW-1:0]  idx_w       [3];
    logic [MAXW-1:0] out_row_w   [3];

    logic [C*(W+2)*DW-1:0] o_p1;
    logic [C*(W+4)*DW-1:0] o_p2;
    logic [IRW-1:0]        o_p0;

    assign out_row_w[0] = MAXW'(o_p1);
    assign out_row_w[1] = o_p2;
    assign out_row_w[2] = MAXW'(o_p0);

    padding_stream #(.DW(DW), .W(W), .H(H), .C(C), .P(1), .RCW(RCW)) u_p1 (
        .clk(clk), .rst_n(rst_n), .start(start_v[0]), .pad_mode(pad_mode),
        .in_valid(in_valid), .in_ready(in_ready_w[0]), .in_row(in_row),
        .out_valid(out_valid_w[0]), .out_ready(out_ready), .out_row(o_p1),
        .out_row_idx(idx_w[0]), .busy(busy_w[0]), .frame_done(fd_w[0]));

    padding_stream #(.DW(DW), .W(W), .H(H), .C(C), .P(2), .RCW(RCW)) u_p2 (
        .clk(clk), .rst_n(rst_n), .start(start_v[1]), .pad_mode(pad_mode),
        .in_valid(in_valid), .in_ready(in_ready_w[1]), .in_row(in_row),
        .out_valid(out_valid_w[1]), .out_ready(out_ready), .out_row(o_p2),
        .out_row_idx(idx_w[1]), .busy(busy_w[1]), .frame_done(fd_w[1]));

    padding_stream #(.DW(DW), .W(W), .H(H), .C(C), .P(0), .RCW(RCW)) u_p0 (
        .clk(clk), .rst_n(rst_n), .start(start_v[2]), .pad_mode(pad_mode),
        .in_valid(in_valid), .in_ready(in_ready_w[2]), .in_row(in_row),
        .out_valid(out_valid_w[2]), .out_ready(out_ready), .out_row(o_p0),
        .out_row_idx(idx_w[2]), .busy(busy_w[2]), .frame_done(fd_w[2]));

    int n_checks = 0;
    int n_fail   = 0;

    logic [IRW-1:0]  rows_q   [H];
    logic [MAXW-1:0] got_rows [8];

    typedef struct {
        bit                 mode;
        logic [2:0][63:0]   r;
        logic [4:0][95:0]   e;
    } vec_t;

    vec_t tbl [2];

    task automatic check(input string name, input logic [MAXW-1:0] got, input logic [MAXW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, got, exp);
        end
    endtask

    function automatic int p_of(input int k);
        return (k == 0) ? 1 : ((k == 1) ? 2 : 0);
    endfunction

    // Reference padding: border pixels clamp to the row edge, or are zero
    function automatic logic [MAXW-1:0] pad_row(input logic [IRW-1:0] src, input int p, input bit mode);
        logic [MAXW-1:0] res;
        int ow;
        res = '0;
        ow  = W + 2 * p;
        for (int c = 0; c < C; c++) begin
            for (int x = 0; x < ow; x++) begin
                int sx;
                logic [DW-1:0] px;
                sx = x - p;
                if (sx < 0 || sx >= W) begin
                    sx = (sx < 0) ? 0 : W - 1;
                    px = mode ? src[(c*W+sx)*DW +: DW] : '0;
                end else begin
                    px = src[(c*W+sx)*DW +: DW];
                end
                res[(c*ow+x)*DW +: DW] = px;
            end
        end
        return res;
    endfunction

    // Expected output row r of a frame built from rows_q
    function automatic logic [MAXW-1:0] model_row(input int p, input bit mode, input int r);
        if (r < p) return mode ? pad_row(rows_q[0], p, mode) : '0;
        if (r < p + H) return pad_row(rows_q[r-p], p, mode);
        return mode ? pad_row(rows_q[H-1], p, mode) : '0;
    endfunction

    task automatic check_reset_outputs(input int k);
        check("rst_out_valid", MAXW'(out_valid_w[k]), '0);
        check("rst_out_row", out_row_w[k], '0);
        check("rst_out_idx", MAXW'(idx_w[k]), '0);
        check("rst_busy", MAXW'(busy_w[k]), '0);
        check("rst_frame_done", MAXW'(fd_w[k]), '0);
        check("rst_in_ready", MAXW'(in_ready_w[k]), '0);
    endtask

    // Runs one frame on instance k; stops early once stop_at rows are consumed
    task automatic run_frame(input int k, input bit mode, input bit rnd, input bit spam, input int stop_at);
        int p, total, consumed, out_acc, fd_cnt, cyc, produced;
        bit hold_pending, lat_pending, acc_in, acc_out, exp_ir;
        logic [MAXW-1:0] hold_row, lat_exp;
        logic [RCW-1:0]  hold_idx;
        p = p_of(k);
        total = H + 2 * p;
        consumed = 0; out_acc = 0; fd_cnt = 0; cyc = 0;
        hold_pending = 1'b0; lat_pending = 1'b0;
        hold_row = '0; lat_exp = '0; hold_idx = '0;
        @(negedge clk);
        start_v[k] = 1'b1; pad_mode = mode; in_valid = 1'b0; out_ready = 1'b1;
        @(posedge clk);
        #1;
        start_v[k] = spam;
        check("busy_after_start", MAXW'(busy_w[k]), MAXW'(1));
        while (out_acc < total && consumed < stop_at && cyc < 500) begin
            @(negedge clk);
            cyc++;
            in_valid  = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
            out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            in_row    = (in_valid && consumed < H) ? rows_q[consumed] : {$urandom, $urandom};
            if (spam) pad_mode = 1'($urandom_range(0, 1));
            #1;
            if (hold_pending) begin
                check("hold_valid", MAXW'(out_valid_w[k]), MAXW'(1));
                check("hold_row", out_row_w[k], hold_row);
                check("hold_idx", MAXW'(idx_w[k]), MAXW'(hold_idx));
            end
            if (lat_pending) begin
                check("latency_valid", MAXW'(out_valid_w[k]), MAXW'(1));
                check("latency_row", out_row_w[k], lat_exp);
            end
            produced = out_acc + (out_valid_w[k] ? 1 : 0);
            exp_ir = (produced >= p && consumed < H) ? (!out_valid_w[k] || out_ready) : 1'b0;
            check("in_ready", MAXW'(in_ready_w[k]), MAXW'(exp_ir));
            acc_in  = in_valid && in_ready_w[k];
            acc_out = out_valid_w[k] && out_ready;
            check("frame_done", MAXW'(fd_w[k]), MAXW'(acc_out && out_acc == total - 1));
            if (fd_w[k]) fd_cnt++;
            if (acc_out) begin
                $display("dut%0d mode%0d row %0d idx %0d: %h", k, mode, out_acc, idx_w[k], out_row_w[k]);
                check("out_row", out_row_w[k], model_row(p, mode, out_acc));
                check("out_idx", MAXW'(idx_w[k]), MAXW'(out_acc));
                got_rows[out_acc] = out_row_w[k];
                out_acc++;
            end
            hold_pending = out_valid_w[k] && !out_ready;
            hold_row     = out_row_w[k];
            hold_idx     = idx_w[k];
            lat_pending  = acc_in;
            lat_exp      = pad_row(in_row, p, mode);
            if (acc_in) consumed++;
        end
        if (stop_at > H) begin
            check("rows_out", MAXW'(out_acc), MAXW'(total));
            @(negedge clk);
            start_v[k] = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
            #1;
            check("busy_after_done", MAXW'(busy_w[k]), '0);
            check("valid_after_done", MAXW'(out_valid_w[k]), '0);
            check("fd_after_done", MAXW'(fd_w[k]), '0);
            check("fd_count", MAXW'(fd_cnt), MAXW'(1));
        end
    endtask

    task automatic random_rows();
        for (int j = 0; j < H; j++) rows_q[j] = {$urandom, $urandom};
    endtask

    initial begin
        for (int k = 0; k < 3; k++) start_v[k] = 1'b0;
        pad_mode = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_row = '0;

        // Directed P=1 frames: ch0 pixels 1..4, ch1 pixels 5..8 in the first row
        tbl[0].mode = 1'b0;
        tbl[0].r[0] = 64'h08070605_04030201;
        tbl[0].r[1] = 64'h18171615_14131211;
        tbl[0].r[2] = 64'h28272625_24232221;
        tbl[0].e[0] = '0;
        tbl[0].e[1] = 96'h000807060500_000403020100;
        tbl[0].e[2] = 96'h001817161500_001413121100;
        tbl[0].e[3] = 96'h002827262500_002423222100;
        tbl[0].e[4] = '0;
        tbl[1].mode = 1'b1;
        tbl[1].r    = tbl[0].r;
        tbl[1].e[0] = 96'h080807060505_040403020101;
        tbl[1].e[1] = 96'h080807060505_040403020101;
        tbl[1].e[2] = 96'h181817161515_141413121111;
        tbl[1].e[3] = 96'h282827262525_242423222121;
        tbl[1].e[4] = 96'h282827262525_242423222121;

        #12;
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 2; i++) begin
            for (int j = 0; j < H; j++) rows_q[j] = tbl[i].r[j];
            run_frame(0, tbl[i].mode, 1'b0, 1'b0, H + 1);
            for (int j = 0; j < 5; j++) check("tbl_row", got_rows[j], MAXW'(tbl[i].e[j]));
        end

        // P=2 with random stalls and back-pressure
        for (int i = 0; i < 3; i++) begin
            random_rows();
            run_frame(1, 1'b0, 1'b1, 1'b0, H + 1);
        end
        random_rows();
        run_frame(1, 1'b1, 1'b1, 1'b0, H + 1);

        // P=0 pass-through, steady and stalled
        random_rows();
        run_frame(2, 1'b0, 1'b0, 1'b0, H + 1);
        random_rows();
        run_frame(2, 1'b1, 1'b1, 1'b0, H + 1);

        // start held high throughout and pad_mode toggling mid-frame
        random_rows();
        run_frame(0, 1'b1, 1'b1, 1'b1, H + 1);
        random_rows();
        run_frame(1, 1'b0, 1'b1, 1'b1, H + 1);

        // Reset asserted mid-body, between clock edges
        random_rows();
        run_frame(0, 1'b0, 1'b0, 1'b0, 2);
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) check_reset_outputs(k);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("fd_in_reset", MAXW'(fd_w[0]), '0);
            check("busy_in_reset", MAXW'(busy_w[0]), '0);
        end
        start_v[0] = 1'b0; in_valid = 1'b0;
        rst_n = 1'b1;
        random_rows();
        run_frame(0, 1'b1, 1'b1, 1'b0, H + 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
